// File: rtl/note_detector.sv
// note_detector: measures the half-period of a single-bit square wave and
// classifies it as one of the notes A..G. A note is reported only after a
// run of consistent half-periods, and dropped on a mismatch or on silence.
// NOM_SHIFT scales the nominal count table down by a power of two for a
// faster clock or bench use; 0 gives the real generator counts.
module note_detector #(
    parameter int TOL            = 64,
    parameter int LOCK_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int NOM_SHIFT      = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wave_in,
    output logic [2:0]  note,
    output logic        note_valid,
    output logic        note_changed,
    output logic [27:0] half_period
);

    localparam int CNT_W = 28;
    localparam int MW    = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [MW-1:0]    LOCK_AT   = MW'(LOCK_COUNT);
    localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Nominal captured half-period for note code k (1 = A .. 7 = G).
    function automatic logic [CNT_W-1:0] nom_of(input logic [2:0] k);
        logic [CNT_W-1:0] base;
        case (k)
            3'd1:    base = 28'd113636;
            3'd2:    base = 28'd101239;
            3'd3:    base = 28'd95556;
            3'd4:    base = 28'd85131;
            3'd5:    base = 28'd75843;
            3'd6:    base = 28'd71586;
            3'd7:    base = 28'd63776;
            default: base = '0;
        endcase
        return base >> NOM_SHIFT;
    endfunction

    // Note code whose window |c - NOM| <= TOL contains c, or 0 if none.
    // Windows are disjoint for sane TOL, so at most one k can hit.
    function automatic logic [2:0] classify(input logic [CNT_W-1:0] c);
        logic signed [CNT_W+1:0] diff;
        logic signed [CNT_W+1:0] tol_s;
        logic [2:0]              cls_f;
        tol_s = $signed((CNT_W+2)'(TOL));
        cls_f = 3'd0;
        for (int k = 1; k < 8; k++) begin
            diff = $signed({2'b00, c}) - $signed({2'b00, nom_of(3'(k))});
            if ((diff <= tol_s) && (diff >= -tol_s)) begin
                cls_f = 3'(k);
            end
        end
        return cls_f;
    endfunction

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cand_q, cand_d;
    logic [MW-1:0]    match_q, match_d;
    state_t           state_q, state_d;
    logic [2:0]       note_q, note_d;
    logic             note_valid_q, note_valid_d;
    logic             note_changed_q, note_changed_d;
    logic [CNT_W-1:0] half_period_q, half_period_d;

    logic             wave_edge;
    logic             at_limit;
    logic             timeout;
    logic [2:0]       cls;
    logic [MW-1:0]    match_inc;
    logic             hp_load;
    logic             enter_lock;

    // Synchronizer, edge detect, saturating period counter and classifier.
    always_comb begin
        s1_d      = wave_in;
        s2_d      = s1_q;
        p_d       = s2_q;
        wave_edge = s2_q ^ p_q;
        at_limit  = (cnt_q == LIMIT);
        // An edge landing on the timeout cycle is a real measurement.
        timeout   = at_limit && !wave_edge;
        if (wave_edge) begin
            cnt_d = '0;
        end else if (at_limit) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 28'd1;
        end
        cls       = classify(cnt_q);
        match_inc = match_q + MATCH_ONE;
    end

    // Next-state logic: acquisition bookkeeping on each edge, timeout to IDLE.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        match_d = match_q;
        hp_load = 1'b0;
        case (state_q)
            IDLE: begin
                // The first edge only starts the counter; its value is junk.
                if (wave_edge) begin
                    state_d = ACQUIRE;
                    cand_d  = '0;
                    match_d = '0;
                end
            end
            ACQUIRE: begin
                if (wave_edge) begin
                    hp_load = 1'b1;
                    if (cls == 3'd0) begin
                        cand_d  = '0;
                        match_d = '0;
                    end else if (cls == cand_q) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_AT) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        cand_d  = cls;
                        match_d = MATCH_ONE;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    match_d = '0;
                end
            end
            LOCKED: begin
                if (wave_edge) begin
                    hp_load = 1'b1;
                    if (cls != note_q) begin
                        state_d = ACQUIRE;
                        cand_d  = cls;
                        match_d = (cls != 3'd0) ? MATCH_ONE : '0;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    match_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: note is presented only while LOCKED, pulse on lock entry.
    always_comb begin
        enter_lock     = (state_d == LOCKED) && (state_q != LOCKED);
        note_d         = 3'd0;
        note_valid_d   = 1'b0;
        note_changed_d = 1'b0;
        if (state_d == LOCKED) begin
            note_valid_d   = 1'b1;
            note_d         = enter_lock ? cand_q : note_q;
            note_changed_d = enter_lock;
        end
        half_period_d = hp_load ? cnt_q : half_period_q;
    end

    // State register: every flop clears on reset, dropping any measurement.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            p_q            <= 1'b0;
            cnt_q          <= '0;
            cand_q         <= '0;
            match_q        <= '0;
            state_q        <= IDLE;
            note_q         <= '0;
            note_valid_q   <= 1'b0;
            note_changed_q <= 1'b0;
            half_period_q  <= '0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            p_q            <= p_d;
            cnt_q          <= cnt_d;
            cand_q         <= cand_d;
            match_q        <= match_d;
            state_q        <= state_d;
            note_q         <= note_d;
            note_valid_q   <= note_valid_d;
            note_changed_q <= note_changed_d;
            half_period_q  <= half_period_d;
        end
    end

    assign note         = note_q;
    assign note_valid   = note_valid_q;
    assign note_changed = note_changed_q;
    assign half_period  = half_period_q;

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector with the nominal table scaled by 2^7.
// Scaled nominals: A 887, B 790, C 746, D 665, E 592, F 559, G 498.
// A wave held H clocks per half-period captures H-1.
module tb_note_detector;

    localparam int TOL = 4;
    localparam int LC  = 4;
    localparam int TO  = 1200;
    localparam int SH  = 7;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wave_in = 1'b0;
    logic [2:0]  note;
    logic        note_valid;
    logic        note_changed;
    logic [27:0] half_period;

    int n_vec = 0;
    int n_bad = 0;
    int chg_cnt = 0;
    int c0;

    note_detector #(
        .TOL(TOL), .LOCK_COUNT(LC), .TIMEOUT_CYCLES(TO), .NOM_SHIFT(SH)
    ) dut (
        .clock(clock), .reset(reset), .wave_in(wave_in),
        .note(note), .note_valid(note_valid), .note_changed(note_changed),
        .half_period(half_period)
    );

    always #5 clock = ~clock;

    // Count note_changed pulses, sampled away from the active edge.
    always @(negedge clock) if (note_changed === 1'b1) chg_cnt++;

    task automatic do_reset();
        wave_in = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Toggle the wave, then hold it for h clocks.
    task automatic half(input int h);
        wave_in = ~wave_in;
        repeat (h) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        n_vec++; if (note !== 3'd0) begin n_bad++; $display("FAIL reset_note: got %0d want 0", note); end
        n_vec++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", note_valid); end
        n_vec++; if (note_changed !== 1'b0) begin n_bad++; $display("FAIL reset_changed: got %0b want 0", note_changed); end
        n_vec++; if (half_period !== 28'd0) begin n_bad++; $display("FAIL reset_hp: got %0d want 0", half_period); end
    endtask

    task automatic test_lock_a();
        do_reset();
        c0 = chg_cnt;
        half(888);
        n_vec++; if (half_period !== 28'd0) begin n_bad++; $display("FAIL a_idle_hp: got %0d want 0", half_period); end
        repeat (3) half(888);
        n_vec++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL a_early_valid: got %0b want 0", note_valid); end
        n_vec++; if (half_period !== 28'd887) begin n_bad++; $display("FAIL a_hp: got %0d want 887", half_period); end
        wave_in = ~wave_in;
        repeat (2) @(posedge clock);
        #1;
        n_vec++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL a_latency_early: got %0b want 0", note_valid); end
        @(posedge clock); #1;
        n_vec++; if (note_valid !== 1'b1) begin n_bad++; $display("FAIL a_valid: got %0b want 1", note_valid); end
        n_vec++; if (note !== 3'd1) begin n_bad++; $display("FAIL a_note: got %0d want 1", note); end
        n_vec++; if (note_changed !== 1'b1) begin n_bad++; $display("FAIL a_changed_hi: got %0b want 1", note_changed); end
        @(posedge clock); #1;
        n_vec++; if (note_changed !== 1'b0) begin n_bad++; $display("FAIL a_changed_lo: got %0b want 0", note_changed); end
        repeat (884) @(posedge clock);
        #1;
        n_vec++; if (chg_cnt - c0 !== 1) begin n_bad++; $display("FAIL a_pulses: got %0d want 1", chg_cnt - c0); end
    endtask

    task automatic test_switch_g();
        c0 = chg_cnt;
        half(499);
        n_vec++; if (note !== 3'd1) begin n_bad++; $display("FAIL g_last_a_note: got %0d want 1", note); end
        half(499);
        n_vec++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL g_drop_valid: got %0b want 0", note_valid); end
        n_vec++; if (note !== 3'd0) begin n_bad++; $display("FAIL g_drop_note: got %0d want 0", note); end
        n_vec++; if (half_period !== 28'd498) begin n_bad++; $display("FAIL g_hp: got %0d want 498", half_period); end
        repeat (2) half(499);
        n_vec++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL g_early_valid: got %0b want 0", note_valid); end
        half(499);
        n_vec++; if (note_valid !== 1'b1) begin n_bad++; $display("FAIL g_valid: got %0b want 1", note_valid); end
        n_vec++; if (note !== 3'd7) begin n_bad++; $display("FAIL g_note: got %0d want 7", note); end
        n_vec++; if (chg_cnt - c0 !== 1) begin n_bad++; $display("FAIL g_pulses: got %0d want 1", chg_cnt - c0); end
    endtask

    task automatic test_no_lock();
        do_reset();
        c0 = chg_cnt;
        for (int i = 0; i < 7; i++) begin
            half(893);
            n_vec++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL nl_valid_%0d: got %0b want 0", i, note_valid); end
        end
        n_vec++; if (note !== 3'd0) begin n_bad++; $display("FAIL nl_note: got %0d want 0", note); end
        n_vec++; if (half_period !== 28'd892) begin n_bad++; $display("FAIL nl_hp: got %0d want 892", half_period); end
        n_vec++; if (chg_cnt - c0 !== 0) begin n_bad++; $display("FAIL nl_pulses: got %0d want 0", chg_cnt - c0); end
    endtask

    task automatic test_tol_edge();
        do_reset();
        repeat (5) half(892);
        n_vec++; if (note_valid !== 1'b1) begin n_bad++; $display("FAIL tol_valid: got %0b want 1", note_valid); end
        n_vec++; if (note !== 3'd1) begin n_bad++; $display("FAIL tol_note: got %0d want 1", note); end
        n_vec++; if (half_period !== 28'd891) begin n_bad++; $display("FAIL tol_hp: got %0d want 891", half_period); end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (4) half(593);
        wave_in = ~wave_in;
        repeat (1203) @(posedge clock);
        #1;
        n_vec++; if (note_valid !== 1'b1) begin n_bad++; $display("FAIL to_before_valid: got %0b want 1", note_valid); end
        n_vec++; if (note !== 3'd5) begin n_bad++; $display("FAIL to_before_note: got %0d want 5", note); end
        @(posedge clock); #1;
        n_vec++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL to_drop_valid: got %0b want 0", note_valid); end
        n_vec++; if (note !== 3'd0) begin n_bad++; $display("FAIL to_drop_note: got %0d want 0", note); end
        n_vec++; if (half_period !== 28'd592) begin n_bad++; $display("FAIL to_hp_hold: got %0d want 592", half_period); end
        // Back in IDLE: the next edge is discarded and does not load half_period.
        half(593);
        n_vec++; if (half_period !== 28'd592) begin n_bad++; $display("FAIL to_idle_hp: got %0d want 592", half_period); end
        repeat (3) half(593);
        n_vec++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL to_relock_early: got %0b want 0", note_valid); end
        half(1201);
        n_vec++; if (note_valid !== 1'b1) begin n_bad++; $display("FAIL to_relock_valid: got %0b want 1", note_valid); end
        n_vec++; if (note !== 3'd5) begin n_bad++; $display("FAIL to_relock_note: got %0d want 5", note); end
    endtask

    // Edge arrives in the very cycle the counter sits at the timeout value.
    task automatic test_edge_vs_timeout();
        half(593);
        n_vec++; if (half_period !== 28'd1200) begin n_bad++; $display("FAIL evt_hp: got %0d want 1200", half_period); end
        n_vec++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL evt_valid: got %0b want 0", note_valid); end
    endtask

    task automatic test_glitch_c();
        do_reset();
        c0 = chg_cnt;
        repeat (5) half(747);
        n_vec++; if (note !== 3'd3) begin n_bad++; $display("FAIL c_lock_note: got %0d want 3", note); end
        half(704);
        n_vec++; if (note_valid !== 1'b1) begin n_bad++; $display("FAIL c_hold_valid: got %0b want 1", note_valid); end
        half(747);
        n_vec++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL c_bad_valid: got %0b want 0", note_valid); end
        n_vec++; if (half_period !== 28'd703) begin n_bad++; $display("FAIL c_bad_hp: got %0d want 703", half_period); end
        repeat (3) half(747);
        n_vec++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL c_relock_early: got %0b want 0", note_valid); end
        half(747);
        n_vec++; if (note_valid !== 1'b1) begin n_bad++; $display("FAIL c_relock_valid: got %0b want 1", note_valid); end
        n_vec++; if (note !== 3'd3) begin n_bad++; $display("FAIL c_relock_note: got %0d want 3", note); end
        n_vec++; if (half_period !== 28'd746) begin n_bad++; $display("FAIL c_relock_hp: got %0d want 746", half_period); end
        n_vec++; if (chg_cnt - c0 !== 2) begin n_bad++; $display("FAIL c_pulses: got %0d want 2", chg_cnt - c0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (5) half(666);
        n_vec++; if (note !== 3'd4) begin n_bad++; $display("FAIL d_lock_note: got %0d want 4", note); end
        do_reset();
        n_vec++; if (note !== 3'd0) begin n_bad++; $display("FAIL d_rst_note: got %0d want 0", note); end
        n_vec++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL d_rst_valid: got %0b want 0", note_valid); end
        n_vec++; if (note_changed !== 1'b0) begin n_bad++; $display("FAIL d_rst_changed: got %0b want 0", note_changed); end
        n_vec++; if (half_period !== 28'd0) begin n_bad++; $display("FAIL d_rst_hp: got %0d want 0", half_period); end
        repeat (4) half(666);
        n_vec++; if (note_valid !== 1'b0) begin n_bad++; $display("FAIL d_reacq_early: got %0b want 0", note_valid); end
        half(666);
        n_vec++; if (note_valid !== 1'b1) begin n_bad++; $display("FAIL d_reacq_valid: got %0b want 1", note_valid); end
        n_vec++; if (note !== 3'd4) begin n_bad++; $display("FAIL d_reacq_note: got %0d want 4", note); end
        n_vec++; if (half_period !== 28'd665) begin n_bad++; $display("FAIL d_reacq_hp: got %0d want 665", half_period); end
    endtask

    initial begin
        test_reset();
        test_lock_a();
        test_switch_g();
        test_no_lock();
        test_tol_edge();
        test_timeout();
        test_edge_vs_timeout();
        test_glitch_c();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
